decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 16, datapath width.
REQ-002 Parameter REG_AW, default 3, register address width (8 registers).
REQ-003 inp_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 inp_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 inp_if_valid  input  1  fetch presents a valid instruction.
REQ-006 inp_if_instr  input  16  instruction: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [5:0] imm6.
REQ-007 out_if_ready  output  1  decode accepts the instruction this cycle.
REQ-008 inp_flush  input  1  discard the instruction in decode and the ID/EX contents.
REQ-009 out_rf_rs, out_rf_rt  output  REG_AW each  register-file read addresses (drive register-file inp_rs/inp_rd).
REQ-010 inp_rf_data1, inp_rf_data2  input  DATA_W each  register-file read data for rs and rt.
REQ-011 inp_wb_wen, inp_wb_addr, inp_wb_data  input  1/REG_AW/DATA_W  writeback port; the same signals also drive the register file.
REQ-012 out_ex_valid, out_ex_op, out_ex_rd, out_ex_wen  output  1/4/REG_AW/1  ID/EX control fields.
REQ-013 out_ex_a, out_ex_b, out_ex_imm  output  DATA_W each  ID/EX operands; imm is imm6 sign-extended.
REQ-014 out_stall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-015 out_rf_rs and out_rf_rt shall be combinational copies of inp_if_instr[8:6] and [5:3].
REQ-016 Bypass: if inp_wb_wen and inp_wb_addr equals a read address, the corresponding operand shall take inp_wb_data instead of register-file data in the same cycle.
REQ-017 Opcodes: ADD 0, SUB 1, AND 2, OR 3, ADDI 4, LW 5, SW 6, BEQ 7, NOP 15; all others decode as NOP.
REQ-018 out_ex_wen is 1 for ADD, SUB, AND, OR, ADDI and LW; otherwise 0.
REQ-019 Source usage: rs is used by every op except NOP; rt is used by ADD, SUB, AND, OR, SW and BEQ.
REQ-020 Load-use hazard: ID/EX holds a valid LW and its rd equals a used source of the incoming valid instruction.
REQ-021 On a hazard: out_if_ready=0, the ID/EX register loads a bubble (valid=0, wen=0), and out_stall_cnt increments unless it is 0xFFFF.
REQ-022 Without a hazard: out_if_ready=1; on the edge, ID/EX latches the decoded fields, with valid equal to inp_if_valid.
REQ-023 An invalid input instruction shall latch as a bubble with out_ex_wen=0.
REQ-024 inp_flush shall override a hazard: out_if_ready=1, the ID/EX register loads a bubble, and the stall counter is not incremented.
REQ-025 Latency: one cycle from acceptance to the out_ex_* outputs; throughput is one instruction per cycle when no hazard is present.
REQ-026 A stall lasts exactly one cycle, because the LW has left ID/EX after one edge.
REQ-027 Bubble fields: op 15, rd 0, a/b/imm 0.

Reset
REQ-028 While inp_rst_n=0, asynchronously: out_ex_valid=0, out_ex_wen=0, out_ex_op=15, out_ex_rd=0, out_ex_a/b/imm=0, out_stall_cnt=0.
REQ-029 Reset asserted mid-stall shall discard the pending instruction; the first cycle after release shall decode normally.

Structure
REQ-030 A shared package shall hold the opcode constants, field bit positions, DATA_W/REG_AW defaults and the NOP encoding.
REQ-031 Sub-module decode_ctrl (combinational op -> wen/uses_rs/uses_rt) is natural; the ID/EX register, bypass, hazard logic and counter shall be in decode_stage.

Verification
REQ-032 r1=12 preloaded; ADD rd=3,rs=1,rt=2 with r2=5 -> next cycle: out_ex_a=12, out_ex_b=5, out_ex_wen=1, out_ex_rd=3.
REQ-033 Writeback r1=14 in the same cycle that decode reads rs=1 -> out_ex_a=14, not the stale register value.
REQ-034 LW rd=4, then ADD rs=4 -> exactly one cycle with out_if_ready=0 and a bubble, then ADD issues; out_stall_cnt=1.
REQ-035 LW rd=4, then ADDI rs=5 with rt field=4 -> no stall, because rt is unused by ADDI.
REQ-036 Flush during a hazard cycle -> bubble latched, out_if_ready=1, out_stall_cnt unchanged.
REQ-037 Reset asserted between edges -> all outputs reach their reset values immediately, without waiting for a clock edge; counter saturation check: force 0xFFFF, then one more stall -> remains 0xFFFF.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_stage_pkg
// Shared definitions for the decode stage: datapath defaults, instruction
// field positions, opcode encodings (including the NOP used for bubbles),
// the stall-counter width and a helper that folds unknown opcodes onto NOP.
// ---------------------------------------------------------------------------
package decode_stage_pkg;

    // Datapath defaults
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned REG_AW_DEF = 3;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned OP_W       = 4;

    // Instruction field positions: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [5:0] imm6
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS_MSB  = 8;
    localparam int unsigned RS_LSB  = 6;
    localparam int unsigned RT_MSB  = 5;
    localparam int unsigned RT_LSB  = 3;
    localparam int unsigned IMM_MSB = 5;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned IMM_W   = IMM_MSB - IMM_LSB + 1;

    // Load-use stall counter
    localparam int unsigned      STALL_CNT_W   = 16;
    localparam logic [15:0]      STALL_CNT_MAX = 16'hFFFF;

    typedef enum logic [OP_W-1:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpAddi = 4'd4,
        OpLw   = 4'd5,
        OpSw   = 4'd6,
        OpBeq  = 4'd7,
        OpNop  = 4'd15
    } op_e;

    localparam logic [OP_W-1:0] NOP_ENC = 4'd15;

    // Unused opcode encodings behave exactly like NOP downstream.
    function automatic op_e op_decode(input logic [OP_W-1:0] raw);
        op_e op;
        case (raw)
            4'd0:    op = OpAdd;
            4'd1:    op = OpSub;
            4'd2:    op = OpAnd;
            4'd3:    op = OpOr;
            4'd4:    op = OpAddi;
            4'd5:    op = OpLw;
            4'd6:    op = OpSw;
            4'd7:    op = OpBeq;
            default: op = OpNop;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
// Bundles the fetch->decode handshake and the ID/EX pipeline-register outputs.
//   inp_if_valid / inp_if_instr / out_if_ready : fetch handshake
//   out_ex_valid / op / rd / wen / a / b / imm : ID/EX contents
// Modports:
//   master : environment side (fetch drives, execute consumes)
//   slave  : decode stage side
// ---------------------------------------------------------------------------
interface decode_stage_if
    import decode_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
);

    logic                  inp_if_valid;
    logic [INSTR_W-1:0]    inp_if_instr;
    logic                  out_if_ready;

    logic                  out_ex_valid;
    logic [OP_W-1:0]       out_ex_op;
    logic [REG_AW-1:0]     out_ex_rd;
    logic                  out_ex_wen;
    logic [DATA_W-1:0]     out_ex_a;
    logic [DATA_W-1:0]     out_ex_b;
    logic [DATA_W-1:0]     out_ex_imm;

    modport master (
        output inp_if_valid,
        output inp_if_instr,
        input  out_if_ready,
        input  out_ex_valid,
        input  out_ex_op,
        input  out_ex_rd,
        input  out_ex_wen,
        input  out_ex_a,
        input  out_ex_b,
        input  out_ex_imm
    );

    modport slave (
        input  inp_if_valid,
        input  inp_if_instr,
        output out_if_ready,
        output out_ex_valid,
        output out_ex_op,
        output out_ex_rd,
        output out_ex_wen,
        output out_ex_a,
        output out_ex_b,
        output out_ex_imm
    );

endinterface

// File: rtl/decode_ctrl.sv
// ---------------------------------------------------------------------------
// decode_ctrl
// Purely combinational opcode classification.
//   inp_op          : decoded opcode (unknown encodings already folded to NOP)
//   out_wen         : instruction writes a destination register
//   out_uses_rs     : instruction reads the rs operand
//   out_uses_rt     : instruction reads the rt operand
// ---------------------------------------------------------------------------
module decode_ctrl
    import decode_stage_pkg::*;
(
    input  op_e  inp_op,
    output logic out_wen,
    output logic out_uses_rs,
    output logic out_uses_rt
);

    always_comb begin
        out_wen     = 1'b0;
        out_uses_rs = 1'b1;
        out_uses_rt = 1'b0;
        unique case (inp_op)
            OpAdd, OpSub, OpAnd, OpOr: begin
                out_wen     = 1'b1;
                out_uses_rt = 1'b1;
            end
            OpAddi, OpLw: begin
                // rt bits overlap imm6 here, so they must not create hazards
                out_wen = 1'b1;
            end
            OpSw, OpBeq: begin
                out_uses_rt = 1'b1;
            end
            default: begin
                out_uses_rs = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Instruction decode with writeback bypass, load-use hazard detection and the
// ID/EX pipeline register.
// Ports:
//   inp_clk, inp_rst_n           : clock, asynchronous active-low reset
//   bus (decode_stage_if.slave)  : fetch handshake in, ID/EX fields out
//   inp_flush                    : drop the decoding instruction, load a bubble
//   out_rf_rs, out_rf_rt         : register-file read addresses
//   inp_rf_data1, inp_rf_data2   : register-file read data (rs, rt)
//   inp_wb_wen/addr/data         : writeback port, bypassed into the operands
//   out_stall_cnt                : saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic                   inp_clk,
    input  logic                   inp_rst_n,
    decode_stage_if.slave          bus,
    input  logic                   inp_flush,
    output logic [REG_AW-1:0]      out_rf_rs,
    output logic [REG_AW-1:0]      out_rf_rt,
    input  logic [DATA_W-1:0]      inp_rf_data1,
    input  logic [DATA_W-1:0]      inp_rf_data2,
    input  logic                   inp_wb_wen,
    input  logic [REG_AW-1:0]      inp_wb_addr,
    input  logic [DATA_W-1:0]      inp_wb_data,
    output logic [STALL_CNT_W-1:0] out_stall_cnt
);

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [OP_W-1:0]   raw_op;
    op_e               dec_op;
    logic [REG_AW-1:0] fld_rd;
    logic [REG_AW-1:0] fld_rs;
    logic [REG_AW-1:0] fld_rt;
    logic [IMM_W-1:0]  fld_imm;
    logic [DATA_W-1:0] imm_ext;

    assign raw_op  = bus.inp_if_instr[OP_MSB:OP_LSB];
    assign dec_op  = op_decode(raw_op);
    assign fld_rd  = REG_AW'(bus.inp_if_instr[RD_MSB:RD_LSB]);
    assign fld_rs  = REG_AW'(bus.inp_if_instr[RS_MSB:RS_LSB]);
    assign fld_rt  = REG_AW'(bus.inp_if_instr[RT_MSB:RT_LSB]);
    assign fld_imm = bus.inp_if_instr[IMM_MSB:IMM_LSB];
    assign imm_ext = {{(DATA_W - IMM_W){fld_imm[IMM_W-1]}}, fld_imm};

    assign out_rf_rs = fld_rs;
    assign out_rf_rt = fld_rt;

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    logic dec_wen;
    logic uses_rs;
    logic uses_rt;

    decode_ctrl u_ctrl (
        .inp_op      (dec_op),
        .out_wen     (dec_wen),
        .out_uses_rs (uses_rs),
        .out_uses_rt (uses_rt)
    );

    // ------------------------------------------------------------------
    // Writeback bypass: the register file is written on the same edge that
    // would latch the operand, so forward the writeback data directly.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    assign opnd_a = (inp_wb_wen && (inp_wb_addr == fld_rs)) ? inp_wb_data : inp_rf_data1;
    assign opnd_b = (inp_wb_wen && (inp_wb_addr == fld_rt)) ? inp_wb_data : inp_rf_data2;

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    logic                   ex_valid_q, ex_valid_d;
    op_e                    ex_op_q,    ex_op_d;
    logic [REG_AW-1:0]      ex_rd_q,    ex_rd_d;
    logic                   ex_wen_q,   ex_wen_d;
    logic [DATA_W-1:0]      ex_a_q,     ex_a_d;
    logic [DATA_W-1:0]      ex_b_q,     ex_b_d;
    logic [DATA_W-1:0]      ex_imm_q,   ex_imm_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // ------------------------------------------------------------------
    // Load-use hazard: the LW in ID/EX only has its data after EX/MEM, so a
    // dependent instruction must wait exactly one cycle. Once the bubble is
    // latched the LW is gone and the hazard clears by itself.
    // ------------------------------------------------------------------
    logic ex_is_load;
    logic hazard;
    logic stall;
    logic load_instr;

    assign ex_is_load = ex_valid_q && (ex_op_q == OpLw);
    assign hazard     = bus.inp_if_valid && ex_is_load &&
                        ((uses_rs && (ex_rd_q == fld_rs)) ||
                         (uses_rt && (ex_rd_q == fld_rt)));
    // Flush wins over the hazard: the instruction is discarded anyway.
    assign stall      = hazard && !inp_flush;
    assign load_instr = bus.inp_if_valid && !inp_flush && !hazard;

    assign bus.out_if_ready = !stall;

    always_comb begin
        // Bubble by default
        ex_valid_d = 1'b0;
        ex_op_d    = OpNop;
        ex_rd_d    = '0;
        ex_wen_d   = 1'b0;
        ex_a_d     = '0;
        ex_b_d     = '0;
        ex_imm_d   = '0;
        if (load_instr) begin
            ex_valid_d = 1'b1;
            ex_op_d    = dec_op;
            ex_rd_d    = fld_rd;
            ex_wen_d   = dec_wen;
            ex_a_d     = opnd_a;
            ex_b_d     = opnd_b;
            ex_imm_d   = imm_ext;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_op_q     <= OpNop;
            ex_rd_q     <= '0;
            ex_wen_q    <= 1'b0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_imm_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_op_q     <= ex_op_d;
            ex_rd_q     <= ex_rd_d;
            ex_wen_q    <= ex_wen_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            ex_imm_q    <= ex_imm_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.out_ex_valid = ex_valid_q;
    assign bus.out_ex_op    = ex_op_q;
    assign bus.out_ex_rd    = ex_rd_q;
    assign bus.out_ex_wen   = ex_wen_q;
    assign bus.out_ex_a     = ex_a_q;
    assign bus.out_ex_b     = ex_b_q;
    assign bus.out_ex_imm   = ex_imm_q;
    assign out_stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    localparam int DW = 16;
    localparam int AW = 3;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic        wen;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
    } ex_t;

    typedef struct {
        logic        ready;
        logic [2:0]  rs;
        logic [2:0]  rt;
        ex_t         ex;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    logic        flush;
    logic [2:0]  rf_rs;
    logic [2:0]  rf_rt;
    logic [15:0] rf_d1;
    logic [15:0] rf_d2;
    logic        wb_wen;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] stall_cnt;

    decode_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .inp_clk       (clk),
        .inp_rst_n     (rst_n),
        .bus           (bus),
        .inp_flush     (flush),
        .out_rf_rs     (rf_rs),
        .out_rf_rt     (rf_rt),
        .inp_rf_data1  (rf_d1),
        .inp_rf_data2  (rf_d2),
        .inp_wb_wen    (wb_wen),
        .inp_wb_addr   (wb_addr),
        .inp_wb_data   (wb_data),
        .out_stall_cnt (stall_cnt)
    );

    // Environment register file (written only by the stimulus process)
    logic [15:0] regs [8];
    assign rf_d1 = regs[rf_rs];
    assign rf_d2 = regs[rf_rt];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: ISA-level rules
    // ------------------------------------------------------------------
    ex_t         m_ex;
    logic [15:0] m_cnt;
    exp_t        sb_q [$];
    logic        obs_ready;

    function automatic ex_t bubble();
        ex_t b;
        b.valid = 1'b0; b.op = 4'd15; b.rd = 3'd0; b.wen = 1'b0;
        b.a = 16'd0; b.b = 16'd0; b.imm = 16'd0;
        return b;
    endfunction

    function automatic exp_t model(input logic v, input logic [15:0] ins, input logic fl,
                                   input logic ww, input logic [2:0] wa, input logic [15:0] wd);
        exp_t        e;
        logic [3:0]  op;
        logic [2:0]  rd, rs, rt;
        logic        reads_rs, reads_rt, writes, hz;
        int          imm_val;
        op = ins[15:12];
        rd = ins[11:9];
        rs = ins[8:6];
        rt = ins[5:3];
        if (!(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15})) op = 4'd15;
        reads_rs = (op != 4'd15);
        reads_rt = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7};
        writes   = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        hz = v && m_ex.valid && (m_ex.op == 4'd5) &&
             ((reads_rs && (m_ex.rd == rs)) || (reads_rt && (m_ex.rd == rt)));
        e.ready = fl || !hz;
        e.rs = rs;
        e.rt = rt;
        if (v && !fl && !hz) begin
            imm_val   = int'(ins[5:0]);
            if (imm_val >= 32) imm_val = imm_val - 64;
            e.ex.valid = 1'b1;
            e.ex.op    = op;
            e.ex.rd    = rd;
            e.ex.wen   = writes;
            e.ex.a     = (ww && (wa == rs)) ? wd : regs[rs];
            e.ex.b     = (ww && (wa == rt)) ? wd : regs[rt];
            e.ex.imm   = 16'(imm_val);
        end else begin
            e.ex = bubble();
        end
        e.cnt = m_cnt;
        if (hz && !fl && (m_cnt != 16'hFFFF)) e.cnt = m_cnt + 16'd1;
        return e;
    endfunction

    // One full clock cycle of stimulus: drive, predict, push, apply writeback.
    task automatic step(input logic v, input logic [15:0] ins, input logic fl,
                        input logic ww, input logic [2:0] wa, input logic [15:0] wd);
        exp_t e;
        @(negedge clk);
        bus.inp_if_valid = v;
        bus.inp_if_instr = ins;
        flush   = fl;
        wb_wen  = ww;
        wb_addr = wa;
        wb_data = wd;
        e = model(v, ins, fl, ww, wa, wd);
        m_ex  = e.ex;
        m_cnt = e.cnt;
        sb_q.push_back(e);
        #2 obs_ready = bus.out_if_ready;
        @(posedge clk);
        #1;
        if (ww) regs[wa] = wd;
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int rt);
        return {4'(op), 3'(rd), 3'(rs), 3'(rt), 3'd0};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, bus.out_ex_valid, 1'b0);
        chk({tag, "_wen"},   bus.out_ex_wen,   1'b0);
        chk({tag, "_op"},    bus.out_ex_op,    4'd15);
        chk({tag, "_rd"},    bus.out_ex_rd,    3'd0);
        chk({tag, "_abimm"}, {bus.out_ex_a, bus.out_ex_b, bus.out_ex_imm}, 48'd0);
        chk({tag, "_cnt"},   stall_cnt,        16'd0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops one expectation per issued cycle
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        ex_t  got;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q[0];
                chk("sb_if_ready", bus.out_if_ready, e.ready);
                chk("sb_rf_addr", {rf_rs, rf_rt}, {e.rs, e.rt});
                @(posedge clk);
                #1;
                got = {bus.out_ex_valid, bus.out_ex_op, bus.out_ex_rd, bus.out_ex_wen,
                       bus.out_ex_a, bus.out_ex_b, bus.out_ex_imm};
                chk("sb_id_ex", got, e.ex);
                chk("sb_stall_cnt", stall_cnt, e.cnt);
                void'(sb_q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic        v, fl, ww;
        logic [15:0] ins;
        bus.inp_if_valid = 1'b0;
        bus.inp_if_instr = 16'hF000;
        flush   = 1'b0;
        wb_wen  = 1'b0;
        wb_addr = 3'd0;
        wb_data = 16'd0;
        obs_ready = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        m_ex  = bubble();
        m_cnt = 16'd0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // ADD r3 = r1 + r2 with r1=12, r2=5
        regs[1] = 16'd12;
        regs[2] = 16'd5;
        step(1'b1, enc(0, 3, 1, 2), 1'b0, 1'b0, 3'd0, 16'd0);
        #1;
        chk("add_a", bus.out_ex_a, 16'd12);
        chk("add_b", bus.out_ex_b, 16'd5);
        chk("add_wen_rd", {bus.out_ex_wen, bus.out_ex_rd}, {1'b1, 3'd3});

        // Writeback to r1 in the same cycle decode reads r1
        step(1'b1, enc(0, 2, 1, 2), 1'b0, 1'b1, 3'd1, 16'd14);
        #1 chk("bypass_a", bus.out_ex_a, 16'd14);

        // LW r4 then ADD using r4 -> one stall cycle
        step(1'b1, enc(5, 4, 0, 0), 1'b0, 1'b0, 3'd0, 16'd0);
        step(1'b1, enc(0, 5, 4, 1), 1'b0, 1'b0, 3'd0, 16'd0);
        chk("lu_ready", obs_ready, 1'b0);
        #1 chk("lu_bubble", bus.out_ex_valid, 1'b0);
        step(1'b1, enc(0, 5, 4, 1), 1'b0, 1'b0, 3'd0, 16'd0);
        chk("lu_issue_ready", obs_ready, 1'b1);
        #1;
        chk("lu_issue", {bus.out_ex_valid, bus.out_ex_op}, {1'b1, 4'd0});
        chk("lu_cnt", stall_cnt, 16'd1);

        // LW r4 then ADDI rs=5 whose rt field is 4 -> no stall
        step(1'b1, enc(5, 4, 0, 0), 1'b0, 1'b0, 3'd0, 16'd0);
        step(1'b1, {4'd4, 3'd6, 3'd5, 6'b100000}, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("addi_ready", obs_ready, 1'b1);
        #1;
        chk("addi_issue", {bus.out_ex_valid, bus.out_ex_op}, {1'b1, 4'd4});
        chk("addi_imm", bus.out_ex_imm, 16'hFFE0);
        chk("addi_cnt", stall_cnt, 16'd1);

        // Flush during a hazard
        step(1'b1, enc(5, 4, 0, 0), 1'b0, 1'b0, 3'd0, 16'd0);
        step(1'b1, enc(0, 5, 4, 1), 1'b1, 1'b0, 3'd0, 16'd0);
        chk("flush_ready", obs_ready, 1'b1);
        #1;
        chk("flush_bubble", bus.out_ex_valid, 1'b0);
        chk("flush_cnt", stall_cnt, 16'd1);

        // Counter saturation
        force dut.stall_cnt_q = 16'hFFFF;
        #1 release dut.stall_cnt_q;
        m_cnt = 16'hFFFF;
        chk("sat_forced", stall_cnt, 16'hFFFF);
        step(1'b1, enc(5, 4, 0, 0), 1'b0, 1'b0, 3'd0, 16'd0);
        step(1'b1, enc(0, 5, 4, 1), 1'b0, 1'b0, 3'd0, 16'd0);
        chk("sat_stall_ready", obs_ready, 1'b0);
        #1 chk("sat_cnt", stall_cnt, 16'hFFFF);

        // Randomized traffic; a stalled instruction is held by fetch
        v = 1'b0;
        ins = 16'hF000;
        for (int n = 0; n < 400; n++) begin
            if (obs_ready || !v) begin
                v   = ($urandom_range(0, 99) < 85);
                ins = {($urandom_range(0, 99) < 30) ? 4'd5 : 4'($urandom_range(0, 15)),
                       3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                       3'($urandom_range(0, 3)), 3'($urandom)};
            end
            fl = ($urandom_range(0, 99) < 8);
            ww = ($urandom_range(0, 1) == 1);
            step(v, ins, fl, ww, 3'($urandom), 16'($urandom));
        end

        // Reset asserted in the middle of a stall cycle
        step(1'b1, enc(5, 4, 0, 0), 1'b0, 1'b0, 3'd0, 16'd0);
        @(negedge clk);
        bus.inp_if_valid = 1'b1;
        bus.inp_if_instr = enc(0, 6, 4, 2);
        flush  = 1'b0;
        wb_wen = 1'b0;
        #2 chk("rst_stall_ready", bus.out_if_ready, 1'b0);
        rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        m_ex  = bubble();
        m_cnt = 16'd0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, enc(0, 6, 4, 2), 1'b0, 1'b0, 3'd0, 16'd0);
        chk("post_rst_ready", obs_ready, 1'b1);
        #1;
        chk("post_rst_issue", {bus.out_ex_valid, bus.out_ex_rd}, {1'b1, 3'd6});
        chk("post_rst_cnt", stall_cnt, 16'd0);

        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
